// File: rtl/rs232_cmd_pkg.sv
// rs232_cmd_pkg: opcodes, response codes, controller states and the
// timeout-limit helper shared by the RS-232 command controller.
package rs232_cmd_pkg;

    localparam logic [7:0] OP_WR   = 8'h57;
    localparam logic [7:0] OP_RD   = 8'h52;
    localparam logic [7:0] RSP_ACK = 8'h4B;
    localparam logic [7:0] RSP_BAD = 8'h3F;
    localparam logic [7:0] RSP_TMO = 8'h21;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_OP_LATCH,
        ST_ADDR_FETCH,
        ST_ADDR_LATCH,
        ST_DATA_FETCH,
        ST_DATA_LATCH,
        ST_EXEC,
        ST_RD_LATCH,
        ST_RESP
    } state_t;

    // Inter-byte timeout in clocks: 10 bit times per character.
    function automatic int unsigned tmo_limit(
        input int unsigned clk_hz,
        input int unsigned baud,
        input int unsigned chars
    );
        return (clk_hz / baud) * 10 * chars;
    endfunction

endpackage

// File: rtl/rs232_cmd_timer.sv
// rs232_cmd_timer: inter-byte timeout counter.
// Ports: clk, rst_n, clear (zero count), enable (count), expired (LIMIT-th enabled cycle).
module rs232_cmd_timer
    import rs232_cmd_pkg::*;
#(
    parameter int unsigned LIMIT = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Fires on the LIMIT-th consecutive enabled cycle after a clear.
    assign expired = enable && !clear && (cnt_q == W'(LIMIT - 1));

endmodule

// File: rtl/rs232_cmd_ctrl.sv
// rs232_cmd_ctrl: pops command frames from the RX FIFO, runs register-bus
// writes/reads and pushes one response byte per command. Optional inter-byte
// timeout under `RS232_CMD_TIMEOUT_EN. Ports: RX FIFO (dout/empty/rd_en),
// TX FIFO (data/wr_en/full), register bus (addr/wdata/wr_en/rd_en/rdata),
// busy and cmd_err status.
module rs232_cmd_ctrl
    import rs232_cmd_pkg::*;
#(
    parameter int unsigned P_CLK_FREQ_HZ   = 33000000,
    parameter int unsigned P_BAUD_RATE     = 9600,
    parameter int unsigned P_TIMEOUT_CHARS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_fifo_dout,
    input  logic       rx_fifo_empty,
    output logic       rx_fifo_rd_en,
    output logic [7:0] tx_fifo_data,
    output logic       tx_fifo_wr_en,
    input  logic       tx_fifo_full,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_wr_en,
    output logic       reg_rd_en,
    input  logic [7:0] reg_rdata,
    output logic       busy,
    output logic       cmd_err
);

    localparam int unsigned TMO_LIMIT =
        tmo_limit(P_CLK_FREQ_HZ, P_BAUD_RATE, P_TIMEOUT_CHARS);

    if (TMO_LIMIT == 0) begin : g_bad_cfg
        $error("rs232_cmd_ctrl: timeout limit evaluates to zero");
    end

    state_t     state_q, state_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] resp_q, resp_d;
    logic       is_wr_q, is_wr_d;
    logic       pop;
    logic       in_fetch;
    logic       tmo;

    assign in_fetch = (state_q == ST_ADDR_FETCH) ||
                      (state_q == ST_DATA_FETCH);

`ifdef RS232_CMD_TIMEOUT_EN
    rs232_cmd_timer #(
        .LIMIT (TMO_LIMIT)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (!in_fetch || pop),
        .enable  (in_fetch && rx_fifo_empty),
        .expired (tmo)
    );
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
            resp_q  <= 8'h00;
            is_wr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            resp_q  <= resp_d;
            is_wr_q <= is_wr_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        resp_d        = resp_q;
        is_wr_d       = is_wr_q;
        pop           = 1'b0;
        reg_wr_en     = 1'b0;
        reg_rd_en     = 1'b0;
        tx_fifo_wr_en = 1'b0;
        cmd_err       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!rx_fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_OP_LATCH;
                end
            end
            ST_OP_LATCH: begin
                unique case (1'b1)
                    (rx_fifo_dout == OP_WR): begin
                        is_wr_d = 1'b1;
                        state_d = ST_ADDR_FETCH;
                    end
                    (rx_fifo_dout == OP_RD): begin
                        is_wr_d = 1'b0;
                        state_d = ST_ADDR_FETCH;
                    end
                    default: begin
                        resp_d  = RSP_BAD;
                        cmd_err = 1'b1;
                        state_d = ST_RESP;
                    end
                endcase
            end
            ST_ADDR_FETCH, ST_DATA_FETCH: begin
                if (!rx_fifo_empty) begin
                    pop     = 1'b1;
                    state_d = (state_q == ST_ADDR_FETCH) ?
                              ST_ADDR_LATCH : ST_DATA_LATCH;
                end else if (tmo) begin
                    // Partial frame is dropped; host sees the timeout code.
                    resp_d  = RSP_TMO;
                    cmd_err = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_ADDR_LATCH: begin
                addr_d  = rx_fifo_dout;
                state_d = is_wr_q ? ST_DATA_FETCH : ST_EXEC;
            end
            ST_DATA_LATCH: begin
                wdata_d = rx_fifo_dout;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (is_wr_q) begin
                    reg_wr_en = 1'b1;
                    resp_d    = RSP_ACK;
                    state_d   = ST_RESP;
                end else begin
                    reg_rd_en = 1'b1;
                    state_d   = ST_RD_LATCH;
                end
            end
            ST_RD_LATCH: begin
                resp_d  = reg_rdata;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (!tx_fifo_full) begin
                    tx_fifo_wr_en = 1'b1;
                    state_d       = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The pop strobe is combinational from !rx_fifo_empty; hold it
    // low while reset is asserted so no byte is lost during reset.
    assign rx_fifo_rd_en = pop && rst_n;
    assign tx_fifo_data  = resp_q;
    assign reg_addr      = addr_q;
    assign reg_wdata     = wdata_q;
    assign busy          = (state_q != ST_IDLE);

endmodule
